// File: rtl/dct_pkg.sv
// Shared DCT defaults and compile-time helpers.
// No logic; constants and a constant function only.
// Used by the transpose buffer and the DCT row/column passes.
package dct_pkg;

  localparam int DCT_N  = 8;
  localparam int DCT_DW = 12;

  // Ceiling log2, for counter and index widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dct_tp_bank.sv
// N x N register bank: one row written per cycle, one row or column read.
// Latency: write lands at the clock edge, read port is combinational.
// Backpressure: none here; the owner guarantees a full bank is never written.
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int N  = DCT_N,
  parameter int DW = DCT_DW,
  parameter int AW = clog2(N)
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            we,
  input  logic [AW-1:0]   wr_row,
  input  logic [N*DW-1:0] wr_data,
  input  logic [AW-1:0]   rd_idx,
  input  logic            rd_mode,
  output logic [N*DW-1:0] rd_data
);

  logic [N*DW-1:0] mem [N];

  // Row storage; cleared only by reset so the idle output reads as zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Element k is column rd_idx of row k (transpose) or element k of row rd_idx (bypass).
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N; k++) begin
      if (rd_mode) rd_data[k*DW +: DW] = mem[k][int'(rd_idx)*DW +: DW];
      else         rd_data[k*DW +: DW] = mem[rd_idx][k*DW +: DW];
    end
  end

endmodule

// File: rtl/dct_transpose_pingpong.sv
// Ping-pong transpose buffer between DCT row and column passes.
// Latency: first vector valid the cycle after the last row of a block is accepted.
// Backpressure: in_ready drops only when both banks hold complete blocks; no out_ready->in_ready path.
module dct_transpose_pingpong
  import dct_pkg::*;
#(
  parameter int N  = DCT_N,
  parameter int DW = DCT_DW
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            clr,
  input  logic            transpose,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            out_last
);

  localparam int AW = clog2(N);
  localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic [1:0]      mode;
  logic            wr_sel;
  logic            rd_sel;
  logic [AW-1:0]   wr_row;
  logic [AW-1:0]   rd_idx;
  logic            in_fire;
  logic            out_fire;
  logic            wr_last;
  logic            rd_last;
  logic [N*DW-1:0] rd_data0;
  logic [N*DW-1:0] rd_data1;

  assign in_ready  = !full[wr_sel];
  assign out_valid = full[rd_sel];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_last   = (wr_row == IDX_LAST);
  assign rd_last   = (rd_idx == IDX_LAST);
  assign out_last  = out_valid && rd_last;
  assign out_data  = rd_sel ? rd_data1 : rd_data0;

  // Fill and drain can complete on different banks at the same edge; apply both.
  always_comb begin
    full_nxt = full;
    if (in_fire && wr_last)  full_nxt[wr_sel] = 1'b1;
    if (out_fire && rd_last) full_nxt[rd_sel] = 1'b0;
  end

  // Write/read counters, bank selects, per-bank mode; clr overrides all traffic.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      full   <= '0;
      mode   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_row <= '0;
      rd_idx <= '0;
    end else if (clr) begin
      full   <= '0;
      mode   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_row <= '0;
      rd_idx <= '0;
    end else begin
      full <= full_nxt;
      if (in_fire) begin
        if (wr_row == '0) mode[wr_sel] <= transpose;
        if (wr_last) begin
          wr_row <= '0;
          wr_sel <= !wr_sel;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (out_fire) begin
        if (rd_last) begin
          rd_idx <= '0;
          rd_sel <= !rd_sel;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

  dct_tp_bank #(.N(N), .DW(DW), .AW(AW)) u_bank0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .we        (in_fire && !clr && !wr_sel),
    .wr_row    (wr_row),
    .wr_data   (in_data),
    .rd_idx    (rd_idx),
    .rd_mode   (mode[0]),
    .rd_data   (rd_data0)
  );

  dct_tp_bank #(.N(N), .DW(DW), .AW(AW)) u_bank1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .we        (in_fire && !clr && wr_sel),
    .wr_row    (wr_row),
    .wr_data   (in_data),
    .rd_idx    (rd_idx),
    .rd_mode   (mode[1]),
    .rd_data   (rd_data1)
  );

endmodule
